// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter feeding a one-deep registered output slot.
// Optional per-requester Gray step checking is enabled with `define GC_STEP_CHECK_EN.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_bin,
  output logic [IDW-1:0]     out_id,
  output logic               out_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [W-1:0]   out_bin_q;
  logic [IDW-1:0] out_id_q;
  logic           out_err_q;

  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic [W-1:0]   win_gray;
  logic [W-1:0]   bin_d;
  logic           err_d;
  logic           slot_free;
  logic           accept;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic multi_bit(input logic [W-1:0] x);
    return (x & (x - W'(1))) != '0;
  endfunction

  // Search starts just after the last winner and wraps around.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr_q) + off) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign win_gray  = req_gray[win_idx*W +: W];
  assign bin_d     = gray2bin(win_gray);
  assign slot_free = !out_valid || out_ready;
  assign accept    = slot_free && win_found;
  assign req_ready = accept ? (N_REQ'(1) << win_idx) : '0;

`ifdef GC_STEP_CHECK_EN
  logic [W-1:0]     hist_q [N_REQ];
  logic [N_REQ-1:0] seen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hist_q[i] <= '0;
      end
    end else if (accept) begin
      hist_q[win_idx] <= win_gray;
      seen_q[win_idx] <= 1'b1;
    end
  end

  assign err_d = seen_q[win_idx] && multi_bit(hist_q[win_idx] ^ win_gray);
`else
  assign err_d = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (|req_valid) state_d = FULL;
      FULL:  if (out_ready && !(|req_valid)) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_q == FULL);
  end

  // Slot payload and arbitration pointer only move on an accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= IDW'(N_REQ - 1);
      out_bin_q <= '0;
      out_id_q  <= '0;
      out_err_q <= 1'b0;
    end else if (accept) begin
      ptr_q     <= win_idx;
      out_bin_q <= bin_d;
      out_id_q  <= win_idx;
      out_err_q <= err_d;
    end
  end

  assign out_bin = out_bin_q;
  assign out_id  = out_id_q;
  assign out_err = out_err_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed and randomized self-checking bench for gray_conv_arbiter.
module tb_gray_conv_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_gray;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_bin;
  logic [IDW-1:0] out_id;
  logic           out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  gray_conv_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_id(out_id), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] g);
    req_gray[i*W +: W] = g;
    req_valid[i]       = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    n_cmp++; if (out_bin !== 4'b0000) begin n_fail++; $display("FAIL rst_bin got=%b want=0000", out_bin); end
    n_cmp++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL rst_id got=%0d want=0", out_id); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b want=0", out_err); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 4'b1000); out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    n_cmp++; if (out_bin !== 4'b1111) begin n_fail++; $display("FAIL single_bin got=%b want=1111", out_bin); end
    n_cmp++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d want=0", out_id); end
    @(negedge clk); req_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_rr();
    logic [IDW-1:0] exp_id  [5];
    logic [W-1:0]   exp_bin [5];
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_bin = '{4'b0100, 4'b1001, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    set_req(0, 4'b0110); set_req(1, 4'b1101); set_req(2, 4'b0001); set_req(3, 4'b0011);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_id !== exp_id[c] || out_bin !== exp_bin[c]) begin
        n_fail++;
        $display("FAIL rr_cycle%0d got v=%0b id=%0d bin=%b want v=1 id=%0d bin=%b",
                 c, out_valid, out_id, out_bin, exp_id[c], exp_bin[c]);
      end
    end
    @(negedge clk); req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 4'b1000); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0; set_req(1, 4'b0001); out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got=%b want=0000", c, req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_bin !== 4'b1111 || out_id !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%0b bin=%b id=%0d want v=1 bin=1111 id=0", c, out_valid, out_bin, out_id);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_bin !== 4'b0001 || out_id !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_reload got v=%0b bin=%b id=%0d want v=1 bin=0001 id=1", out_valid, out_bin, out_id);
    end
    @(negedge clk); req_valid = '0; out_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pre_full got=%0b want=1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_bin !== 4'b0000) begin
      n_fail++;
      $display("FAIL mr_cleared got v=%0b id=%0d bin=%b want v=0 id=0 bin=0000", out_valid, out_id, out_bin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2, 4'b0001); set_req(0, 4'b0110); out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_prio_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_id !== 2'd0 || out_bin !== 4'b0100) begin
      n_fail++; $display("FAIL mr_first got id=%0d bin=%b want id=0 bin=0100", out_id, out_bin);
    end
    @(negedge clk); req_valid[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_id !== 2'd2 || out_bin !== 4'b0001) begin
      n_fail++; $display("FAIL mr_second got id=%0d bin=%b want id=2 bin=0001", out_id, out_bin);
    end
    @(negedge clk); req_valid = '0;
  endtask

  task automatic test_step_check();
    logic [W-1:0] gseq [3];
    logic [W-1:0] bseq [3];
    logic         eseq [3];
    gseq = '{4'b0000, 4'b0011, 4'b0010};
    bseq = '{4'b0000, 4'b0010, 4'b0011};
`ifdef GC_STEP_CHECK_EN
    eseq = '{1'b0, 1'b1, 1'b0};
`else
    eseq = '{1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(1, gseq[c]);
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_bin !== bseq[c] || out_err !== eseq[c]) begin
        n_fail++;
        $display("FAIL step%0d got v=%0b id=%0d bin=%b err=%0b want v=1 id=1 bin=%b err=%0b",
                 c, out_valid, out_id, out_bin, out_err, bseq[c], eseq[c]);
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_stress();
    logic [N-1:0]   pv;
    logic [W-1:0]   pw [N];
    logic           m_valid, m_err, free, found;
    logic [W-1:0]   m_bin;
    logic [IDW-1:0] m_id;
    int             m_ptr, w, n_acc;
    logic [N-1:0]   exp_rr;
    logic [W-1:0]   m_hist [N];
    logic [N-1:0]   m_seen;
    do_reset();
    pv = '0; m_valid = 1'b0; m_err = 1'b0; m_bin = '0; m_id = '0; m_ptr = N - 1; n_acc = 0;
    m_seen = '0;
    for (int i = 0; i < N; i++) begin pw[i] = '0; m_hist[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pw[i] = W'($urandom_range(0, (1 << W) - 1));
        end
        req_gray[i*W +: W] = pw[i];
      end
      req_valid = pv;
      out_ready = ($urandom_range(0, 3) != 0);
      free  = !m_valid || out_ready;
      found = 1'b0; w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pv[(m_ptr + k) % N]) begin found = 1'b1; w = (m_ptr + k) % N; end
      end
      exp_rr = (free && found) ? (N'(1) << w) : '0;
      #1;
      n_cmp++; if (req_ready !== exp_rr) begin
        n_fail++; $display("FAIL stress_ready c=%0d got=%b want=%b", c, req_ready, exp_rr);
      end
      @(posedge clk);
      if (free && found) begin
        m_valid = 1'b1;
        m_bin   = ref_g2b(pw[w]);
        m_id    = IDW'(w);
`ifdef GC_STEP_CHECK_EN
        m_err   = m_seen[w] && ($countones(m_hist[w] ^ pw[w]) > 1);
`else
        m_err   = 1'b0;
`endif
        m_hist[w] = pw[w];
        m_seen[w] = 1'b1;
        m_ptr   = w;
        pv[w]   = 1'b0;
        n_acc++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      #1;
      n_cmp++; if (out_valid !== m_valid) begin
        n_fail++; $display("FAIL stress_valid c=%0d got=%0b want=%0b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++; if (out_bin !== m_bin || out_id !== m_id || out_err !== m_err) begin
          n_fail++;
          $display("FAIL stress_data c=%0d got bin=%b id=%0d err=%0b want bin=%b id=%0d err=%0b",
                   c, out_bin, out_id, out_err, m_bin, m_id, m_err);
        end
      end
      @(negedge clk);
    end
    n_cmp++; if (n_acc < 50) begin n_fail++; $display("FAIL stress_activity got=%0d want>=50", n_acc); end
    req_valid = '0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_mid_reset();
    test_step_check();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
